chunked_adder_seq: RTL and testbench
====================================

Name: chunked_adder_seq

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the fixed 8-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first. A carry register links the chunks.
- Uses a START/BUSY/DONE handshake and holds its result registered until the next operation.
- Sits in datapaths where a full-width ripple chain does not meet timing, or where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1.
- CHUNK, 2, bits processed per cycle; WIDTH must be a multiple of CHUNK. Elaboration-time error otherwise.
- N (localparam) = WIDTH/CHUNK, number of RUN cycles.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only in IDLE.
- SUB  in  1  0 = add, 1 = subtract (A − B); captured with START.
- A  in  WIDTH  operand A; captured with START.
- B  in  WIDTH  operand B; captured with START.
- CIN  in  1  carry-in for add; ignored when SUB=1.
- BUSY  out  1  high while operation in progress.
- DONE  out  1  one-cycle pulse; result valid.
- F  out  WIDTH  result, registered.
- COUT  out  1  carry-out of MSB. For subtract, COUT=1 means no borrow (A ≥ B unsigned).
- OVF  out  1  two's-complement signed overflow.

Behaviour:
- Reset (RST_N low, asynchronous, any time):
  - state=IDLE; BUSY=0, DONE=0, F=0, COUT=0, OVF=0.
  - Internal operand, carry and chunk counter cleared.
  - An operation in flight is abandoned; no DONE is produced after release.
- States: IDLE, RUN.
- IDLE:
  - On an edge with START=1, capture A, B and SUB.
  - Capture the effective B as ~B when SUB=1, else B.
  - Capture carry = 1 when SUB=1, else CIN.
  - Clear chunk index; go to RUN; BUSY=1 from this edge.
  - START=0: stay in IDLE; outputs hold.
- RUN:
  - Each edge adds chunk i of A, chunk i of effective B and the carry register.
  - Stores the CHUNK sum bits into internal result position i, updates carry, increments i.
  - On the edge that processes chunk N−1:
    - F ← full internal result; COUT ← final carry.
    - OVF ← (A[MSB] == effB[MSB]) && (F[MSB] != A[MSB]).
    - DONE ← 1, BUSY ← 0, state ← IDLE.
- Latency: START sampled at edge k → DONE high in the cycle after edge k+N, with F/COUT/OVF valid at the same time.
- Throughput: one operation per N+1 cycles. A START held high during the DONE cycle is accepted at edge k+N+1.
- DONE is high for exactly one cycle and then returns to 0 automatically.
- F, COUT and OVF remain stable through IDLE and through the entire next RUN. They change only on a completion edge.
- START during RUN is ignored. It is not queued and has no effect on captured operands.
- Changes on A, B, SUB and CIN after capture do not affect the operation in flight.
- CHUNK=WIDTH degenerates to N=1: DONE one edge after START.
- Arithmetic is unsigned modulo 2^WIDTH for F. COUT and OVF follow standard adder semantics on the effective operands.

Test Plan:
- WIDTH=8, CHUNK=2, SUB=0, A=8'hFF, B=8'h01, CIN=0, START pulse at edge k:
  - BUSY=1 for edges k..k+3.
  - DONE=1 after edge k+4 only.
  - F=8'h00, COUT=1, OVF=0.
- SUB=0, A=8'h7F, B=8'h01, CIN=0 → F=8'h80, COUT=0, OVF=1. Then A=8'h10, B=8'h20, CIN=1 → F=8'h31, COUT=0, OVF=0.
- SUB=1, A=8'h05, B=8'h07, CIN=1 (ignored) → F=8'hFE, COUT=0, OVF=0. Then A=8'h80, B=8'h01 → F=8'h7F, COUT=1, OVF=1.
- Busy rejection:
  - Start A=8'h01, B=8'h01.
  - During RUN, assert START with A=8'hAA, B=8'h55 and change the A/B pins.
  - Required: F=8'h02 at DONE, only one DONE pulse, BUSY low after.
- Mid-operation reset:
  - RST_N low for 3 ns during the 2nd RUN cycle, with a prior F=8'h02.
  - Required: F=0, BUSY=0, DONE=0 immediately, before any clock edge.
  - No DONE in the following 10 cycles with START=0.
- Parameter sweep: WIDTH=16/CHUNK=4 and WIDTH=8/CHUNK=8, 1000 random operands each. Check against a golden {COUT,F}=A+effB+carry, and check DONE latency of 4 and 1 cycles respectively.

Source files
------------

// File: rtl/chunked_adder_seq_if.sv
// Handshake and operand/result bundle for chunked_adder_seq.
// The master side requests operations; the slave side is the adder.
interface chunked_adder_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             START;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] F;
    logic             COUT;
    logic             OVF;

    modport master (
        output START, SUB, A, B, CIN,
        input  BUSY, DONE, F, COUT, OVF
    );

    modport slave (
        input  START, SUB, A, B, CIN,
        output BUSY, DONE, F, COUT, OVF
    );
endinterface

// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// with a carry register between chunks. Result held registered until the next completion.
module chunked_adder_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic CLK,
    input  logic RST_N,
    chunked_adder_seq_if.slave bus
);
    localparam int unsigned N    = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("chunked_adder_seq: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  f_q, f_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [CHUNK:0]    sum;
    logic              last_chunk;
    int unsigned       base;

    assign last_chunk = (idx_q == IDXW'(N - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.START) state_d = RUN;
            RUN:     if (last_chunk) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1, so only the effective B and initial carry are stored.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        f_d     = f_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        base    = CHUNK * 32'(idx_q);
        sum     = '0;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    a_d     = bus.A;
                    b_d     = bus.SUB ? ~bus.B : bus.B;
                    carry_d = bus.SUB | bus.CIN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_q};
                res_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d = sum[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (last_chunk) begin
                    f_d    = res_d;
                    cout_d = sum[CHUNK];
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    done_d = 1'b1;
                    idx_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.BUSY = (state_q == RUN);
        bus.DONE = done_q;
        bus.F    = f_q;
        bus.COUT = cout_q;
        bus.OVF  = ovf_q;
    end
endmodule

// File: tb/tb_chunked_adder_seq.sv
// Directed checks of chunked_adder_seq at 8/2, plus random sweeps at 16/4 and 8/8
// against a full-width golden sum.
module tb_chunked_adder_seq;
    logic CLK;
    logic RST_N;
    int   vectors;
    int   miscompares;

    chunked_adder_seq_if #(.WIDTH(8))  if8  ();
    chunked_adder_seq_if #(.WIDTH(16)) if16 ();
    chunked_adder_seq_if #(.WIDTH(8))  if88 ();

    chunked_adder_seq #(.WIDTH(8),  .CHUNK(2)) u_dut8  (.CLK(CLK), .RST_N(RST_N), .bus(if8));
    chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) u_dut16 (.CLK(CLK), .RST_N(RST_N), .bus(if16));
    chunked_adder_seq #(.WIDTH(8),  .CHUNK(8)) u_dut88 (.CLK(CLK), .RST_N(RST_N), .bus(if88));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One 8/2 operation: START at edge k, BUSY checked each cycle until DONE.
    task automatic op8(input string tag, input logic sub, input logic [7:0] a,
                       input logic [7:0] b, input logic cin, input logic [7:0] ef,
                       input logic ec, input logic eo);
        int lat;
        if8.SUB = sub; if8.A = a; if8.B = b; if8.CIN = cin; if8.START = 1'b1;
        tick();
        if8.START = 1'b0;
        lat = 0;
        while (!if8.DONE && lat < 20) begin
            chk({tag, "_busy"}, 32'(if8.BUSY), 32'd1);
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_F"},    32'(if8.F),    32'(ef));
        chk({tag, "_COUT"}, 32'(if8.COUT), 32'(ec));
        chk({tag, "_OVF"},  32'(if8.OVF),  32'(eo));
        chk({tag, "_busy_done"}, 32'(if8.BUSY), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(if8.DONE), 32'd0);
        chk({tag, "_F_hold"}, 32'(if8.F), 32'(ef));
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic        sub;
        logic        cin;
        logic        c0;
        logic [15:0] a16, b16, e16;
        logic [16:0] s16;
        logic [7:0]  a8, b8, e8;
        logic [8:0]  s8;

        vectors = 0;
        miscompares = 0;
        RST_N = 1'b0;
        {if8.START, if8.SUB, if8.A, if8.B, if8.CIN}       = '0;
        {if16.START, if16.SUB, if16.A, if16.B, if16.CIN}  = '0;
        {if88.START, if88.SUB, if88.A, if88.B, if88.CIN}  = '0;

        #2;
        chk("rst_BUSY", 32'(if8.BUSY), 32'd0);
        chk("rst_DONE", 32'(if8.DONE), 32'd0);
        chk("rst_F",    32'(if8.F),    32'd0);
        chk("rst_COUT", 32'(if8.COUT), 32'd0);
        chk("rst_OVF",  32'(if8.OVF),  32'd0);
        chk("rst_F16",  32'(if16.F),   32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        op8("add_ff_01",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7f_01",  1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("add_10_20c", 1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
        op8("sub_05_07",  1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_80_01",  1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

        // START and operand changes during RUN must be ignored.
        if8.SUB = 1'b0; if8.A = 8'h01; if8.B = 8'h01; if8.CIN = 1'b0; if8.START = 1'b1;
        tick();
        if8.A = 8'hAA; if8.B = 8'h55;
        tick();
        chk("busy_F_stable", 32'(if8.F), 32'h7F);
        tick();
        if8.START = 1'b0; if8.A = 8'h33; if8.SUB = 1'b1; if8.CIN = 1'b1;
        lat = 0;
        while (!if8.DONE && lat < 20) begin
            tick();
            lat++;
        end
        chk("busy_lat", 32'(lat), 32'd2);
        chk("busy_F", 32'(if8.F), 32'h02);
        chk("busy_COUT", 32'(if8.COUT), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if8.DONE) pulses++;
        end
        chk("busy_extra_done", 32'(pulses), 32'd0);
        chk("busy_low_after", 32'(if8.BUSY), 32'd0);

        // Asynchronous reset in the second RUN cycle.
        if8.SUB = 1'b0; if8.A = 8'h10; if8.B = 8'h10; if8.CIN = 1'b0; if8.START = 1'b1;
        tick();
        if8.START = 1'b0;
        tick();
        chk("mid_F_prior", 32'(if8.F), 32'h02);
        chk("mid_busy", 32'(if8.BUSY), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_F",    32'(if8.F),    32'd0);
        chk("mid_rst_BUSY", 32'(if8.BUSY), 32'd0);
        chk("mid_rst_DONE", 32'(if8.DONE), 32'd0);
        #2 RST_N = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if8.DONE) pulses++;
        end
        chk("mid_no_done", 32'(pulses), 32'd0);

        // 16/4 sweep.
        for (int n = 0; n < 1000; n++) begin
            a16 = 16'($urandom); b16 = 16'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            e16 = sub ? ~b16 : b16;
            c0  = sub ? 1'b1 : cin;
            s16 = {1'b0, a16} + {1'b0, e16} + {16'd0, c0};
            if16.A = a16; if16.B = b16; if16.SUB = sub; if16.CIN = cin; if16.START = 1'b1;
            tick();
            if16.START = 1'b0;
            lat = 0;
            while (!if16.DONE && lat < 20) begin
                tick();
                lat++;
            end
            chk("w16_lat",  32'(lat), 32'd4);
            chk("w16_F",    32'(if16.F), 32'(s16[15:0]));
            chk("w16_COUT", 32'(if16.COUT), 32'(s16[16]));
            chk("w16_OVF",  32'(if16.OVF),
                32'((a16[15] == e16[15]) && (s16[15] != a16[15])));
        end

        // 8/8 sweep: single-cycle RUN.
        for (int n = 0; n < 1000; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            sub = 1'($urandom); cin = 1'($urandom);
            e8 = sub ? ~b8 : b8;
            c0 = sub ? 1'b1 : cin;
            s8 = {1'b0, a8} + {1'b0, e8} + {8'd0, c0};
            if88.A = a8; if88.B = b8; if88.SUB = sub; if88.CIN = cin; if88.START = 1'b1;
            tick();
            if88.START = 1'b0;
            lat = 0;
            while (!if88.DONE && lat < 20) begin
                tick();
                lat++;
            end
            chk("w8_lat",  32'(lat), 32'd1);
            chk("w8_F",    32'(if88.F), 32'(s8[7:0]));
            chk("w8_COUT", 32'(if88.COUT), 32'(s8[8]));
            chk("w8_OVF",  32'(if88.OVF),
                32'((a8[7] == e8[7]) && (s8[7] != a8[7])));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
